// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding imem read, results buffered toward decode.
// Define FETCH_MISALIGN_TRAP_EN to turn misaligned PCs into fault entries.
module instruction_fetch #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    output logic            pc_count,
    input  logic            flush,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_data,
    output logic [XLEN-1:0] instr_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            instr_fault
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP,
        S_STALL
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] data_mem [FIFO_DEPTH];
    logic [XLEN-1:0] pc_mem   [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic            push, pop, credit;
    logic [XLEN-1:0] push_pc, push_data;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            push_fault;
    logic            fault_mem [FIFO_DEPTH];
`endif

    // Requests are only issued from IDLE, where nothing is outstanding
    assign credit      = count < FULL;
    assign pop         = instr_ready && (count != '0);
    assign instr_valid = count != '0;
    assign instr_data  = data_mem[rd_ptr];
    assign instr_pc    = pc_mem[rd_ptr];
    assign imem_addr   = addr_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign instr_fault = fault_mem[rd_ptr];
`endif

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        push           = 1'b0;
        push_pc        = addr_q;
        push_data      = imem_rsp_data;
        pc_count       = 1'b0;
        imem_req_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        push_fault     = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (!flush && credit) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (pc[1:0] != 2'b00) begin
                        push       = 1'b1;
                        push_pc    = pc;
                        push_data  = '0;
                        push_fault = 1'b1;
                        state_d    = S_STALL;
                    end else begin
                        addr_d  = pc;
                        state_d = S_REQ;
                    end
`else
                    addr_d  = pc;
                    state_d = S_REQ;
`endif
                end
            end
            S_REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    pc_count = !flush;
                    state_d  = flush ? S_DROP : S_WAIT;
                end else if (flush) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    push    = !flush;
                    state_d = S_IDLE;
                end else if (flush) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid) state_d = S_IDLE;
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            S_STALL: begin
                if (flush) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
                fault_mem[i] <= 1'b0;
`endif
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                data_mem[wr_ptr] <= push_data;
                pc_mem[wr_ptr]   <= push_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
                fault_mem[wr_ptr] <= push_fault;
`endif
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop) count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed + randomized bench for instruction_fetch.
// Memory, PC and decode queue are modelled at transaction level.
module tb_instruction_fetch;

    localparam int DEPTH = 2;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        pc_count;
    logic        flush;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        instr_fault;
`endif

    instruction_fetch #(.XLEN(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .pc_count       (pc_count),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .instr_fault    (instr_fault)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_acc, n_pcc, n_reqv;
    int          lat_max;
    int          pend_cnt;
    bit          pend, pend_live, model_en;
    bit          s_acc, s_pcc;
    logic [31:0] pend_addr, last_acc_addr, flush_target;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: observe at negedge, update models, drive after posedge
    task automatic tick();
        bit          fl, rsp, pop;
        logic [31:0] pc_next;
        @(negedge clk);
        fl    = flush;
        rsp   = imem_rsp_valid;
        pop   = instr_valid && instr_ready;
        s_acc = imem_req_valid && imem_req_ready;
        s_pcc = pc_count;
        if (model_en) begin
            chk("instr_valid", instr_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("head_pc", instr_pc, q[0].pc);
                chk("head_data", instr_data, q[0].data);
            end
            chk("pc_count", pc_count, s_acc && !fl);
            if (s_acc) chk("req_addr", imem_addr, pc);
            if (imem_req_valid) begin
                chk("req_credit", q.size() < DEPTH, 1);
                chk("req_single", pend, 0);
            end
        end
        if (imem_req_valid) n_reqv++;
        if (s_pcc) n_pcc++;
        if (s_acc) begin
            n_acc++;
            last_acc_addr = imem_addr;
        end
        if (fl) begin
            q.delete();
        end else begin
            if (pop && q.size() != 0) void'(q.pop_front());
            if (rsp && pend && pend_live)
                q.push_back('{pend_addr, mdata(pend_addr)});
        end
        if (rsp) pend = 0;
        if (fl) pend_live = 0;
        if (s_acc) begin
            pend      = 1;
            pend_live = !fl;
            pend_addr = imem_addr;
            pend_cnt  = $urandom_range(1, lat_max);
        end
        if (fl) pc_next = flush_target;
        else if (s_pcc) pc_next = pc + 32'd4;
        else pc_next = pc;
        @(posedge clk);
        #1;
        pc = pc_next;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (pend && pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mdata(pend_addr);
            end
        end
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 30 && !instr_valid; i++) tick();
        chk(tag, instr_valid, 1);
    endtask

    task automatic wait_acc(input string tag);
        n_acc = 0;
        for (int i = 0; i < 30 && n_acc == 0; i++) tick();
        chk(tag, n_acc, 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_reqv"}, imem_req_valid, 0);
        chk({tag, "_pcc"}, pc_count, 0);
        chk({tag, "_ivalid"}, instr_valid, 0);
        chk({tag, "_addr"}, imem_addr, 0);
        chk({tag, "_idata"}, instr_data, 0);
        chk({tag, "_ipc"}, instr_pc, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset          = 1'b1;
        pc             = '0;
        flush          = 1'b0;
        flush_target   = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        instr_ready    = 1'b0;
        lat_max        = 1;
        model_en       = 1;
        pend           = 0;
        pend_live      = 0;
        #2 reset = 1'b0;
        #1 check_zero("reset");
        repeat (2) tick();
        reset = 1'b1;

        // First fetch from pc 0, one-cycle memory
        imem_req_ready = 1'b1;
        n_pcc = 0;
        n_acc = 0;
        wait_valid("t1_valid");
        chk("t1_pc", instr_pc, 32'h0);
        chk("t1_data", instr_data, 32'h0000_0013);
        chk("t1_pcc_once", n_pcc, 1);
        chk("t1_addr", last_acc_addr, 32'h0);

        // Stall decode: two entries fill, then requests stop
        n_acc = 0;
        repeat (12) tick();
        chk("t2_acc", n_acc, 1);
        chk("t2_reqv_idle", imem_req_valid, 0);
        chk("t2_pc", pc, 32'h8);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("t2_head_after_pop", instr_pc, 32'h4);
        n_acc = 0;
        repeat (10) tick();
        chk("t2_refill_acc", n_acc, 1);
        chk("t2_refill_addr", last_acc_addr, 32'h8);
        chk("t2_reqv_idle2", imem_req_valid, 0);

        // Flush coinciding with a response in WAIT
        imem_req_ready = 1'b0;
        instr_ready    = 1'b1;
        repeat (6) tick();
        instr_ready    = 1'b0;
        imem_req_ready = 1'b1;
        lat_max        = 3;
        for (int i = 0; i < 30 && !imem_rsp_valid; i++) tick();
        tick();
        for (int i = 0; i < 30 && !imem_rsp_valid; i++) tick();
        chk("t3_rsp_seen", imem_rsp_valid, 1);
        flush        = 1'b1;
        flush_target = 32'h100;
        tick();
        flush = 1'b0;
        chk("t3_empty", instr_valid, 0);
        wait_acc("t3_acc");
        chk("t3_addr", last_acc_addr, 32'h100);

        // Flush on the acceptance cycle: response dropped
        for (int i = 0; i < 30 && !imem_req_valid; i++) tick();
        chk("t4_reqv", imem_req_valid, 1);
        flush        = 1'b1;
        flush_target = 32'h200;
        tick();
        flush = 1'b0;
        chk("t4_acc", s_acc, 1);
        chk("t4_pcc", s_pcc, 0);
        wait_valid("t4_valid");
        chk("t4_pc", instr_pc, 32'h200);
        chk("t4_data", instr_data, mdata(32'h200));

        // Asynchronous reset while a response is outstanding
        instr_ready = 1'b1;
        wait_acc("t5_acc");
        #1 reset = 1'b0;
        #1 check_zero("t5");
        q.delete();
        pend           = 0;
        pend_live      = 0;
        imem_rsp_valid = 1'b0;
        pc             = '0;
        instr_ready    = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        wait_acc("t5_restart");
        chk("t5_addr", last_acc_addr, 32'h0);
        wait_valid("t5_valid");
        chk("t5_pc", instr_pc, 32'h0);

        // Randomized traffic against the queue model
        for (int i = 0; i < 600; i++) begin
            imem_req_ready = ($urandom % 10) < 7;
            instr_ready    = $urandom % 2;
            flush          = ($urandom % 20) == 0;
            flush_target   = $urandom & 32'h0000_FFFC;
            tick();
        end
        flush       = 1'b0;
        instr_ready = 1'b1;
        repeat (10) tick();

`ifdef FETCH_MISALIGN_TRAP_EN
        // Misaligned PC becomes a fault entry, no memory traffic
        model_en       = 0;
        instr_ready    = 1'b0;
        imem_req_ready = 1'b1;
        flush          = 1'b1;
        flush_target   = 32'h2;
        tick();
        flush  = 1'b0;
        n_reqv = 0;
        n_pcc  = 0;
        wait_valid("t7_valid");
        chk("t7_fault", instr_fault, 1);
        chk("t7_pc", instr_pc, 32'h2);
        chk("t7_data", instr_data, 32'h0);
        repeat (6) tick();
        chk("t7_noreq", n_reqv, 0);
        chk("t7_nopcc", n_pcc, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
